// File: rtl/pwm_cfg_arbiter.sv
// Round-robin register-write arbiter feeding a shadowed three-channel PWM.
// Writes land in shadow registers and are copied to the active set only at a counter wrap.
module pwm_cfg_arbiter #(
   parameter int CNT_W = 8,
   parameter int NCH   = 3
) (
   input  logic                 ram_clk,
   input  logic                 sys_rst_l,
   input  logic [NCH-1:0]       req_i,
   input  logic [2*NCH-1:0]     addr_i,
   input  logic [NCH*CNT_W-1:0] data_i,
   output logic [NCH-1:0]       gnt_o,
   output logic                 commit_o,
   output logic [CNT_W-1:0]     cnt_o,
   output logic [NCH-1:0]       pwm_o
);

   localparam int NREG = NCH + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [NCH-1:0]   gnt_q, gnt_d;
   logic [1:0]       win_q, win_d;
   logic [1:0]       last_q, last_d;
   logic [CNT_W-1:0] shadow_q [NREG];
   logic [CNT_W-1:0] shadow_d [NREG];
   logic [CNT_W-1:0] active_q [NREG];
   logic [CNT_W-1:0] active_d [NREG];
   logic             dirty_q, dirty_d;
   logic             commit_q, commit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NCH-1:0]   pwm_q, pwm_d;

   logic [1:0]       req_addr [NCH];
   logic [CNT_W-1:0] req_data [NCH];
   logic [1:0]       rr_cand  [NCH];
   logic             win_valid;
   logic [1:0]       win_idx;
   logic             wr_en;
   logic [1:0]       wr_addr;
   logic [CNT_W-1:0] wr_data;
   logic             wrap;
   logic             commit_now;

   // rr_cand[k] is the requester examined k-th, starting just after the last grant.
   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         logic [2:0] rr_sum;
         assign req_addr[gi] = addr_i[2*gi +: 2];
         assign req_data[gi] = data_i[CNT_W*gi +: CNT_W];
         assign rr_sum       = {1'b0, last_q} + 3'(gi + 1);
         assign rr_cand[gi]  = (rr_sum >= 3'(NCH)) ? 2'(rr_sum - 3'(NCH)) : rr_sum[1:0];
         assign pwm_d[gi]    = (cnt_q < active_q[gi+1]);
      end
   endgenerate

   always_comb begin
      win_valid = 1'b0;
      win_idx   = 2'd0;
      for (int k = NCH-1; k >= 0; k--) begin
         if (req_i[rr_cand[k]]) begin
            win_valid = 1'b1;
            win_idx   = rr_cand[k];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = '0;
      win_d   = win_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               state_d        = ST_GNT;
               gnt_d[win_idx] = 1'b1;
               win_d          = win_idx;
               last_d         = win_idx;
            end
         end
         ST_GNT:  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign wr_en   = (state_q == ST_GNT);
   assign wr_addr = req_addr[win_q];
   assign wr_data = req_data[win_q];

   // The compare uses the active period, so a shrinking period can never skip the wrap.
   assign wrap       = (cnt_q == active_q[0]);
   assign commit_now = wrap & dirty_q;

   always_comb begin
      cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
      shadow_d = shadow_q;
      active_d = active_q;
      // Active copies take the shadow values from before any same-cycle write.
      if (commit_now) begin
         active_d = shadow_q;
      end
      if (wr_en) begin
         shadow_d[wr_addr] = wr_data;
      end
      dirty_d = dirty_q;
      if (wr_en) begin
         dirty_d = 1'b1;
      end else if (commit_now) begin
         dirty_d = 1'b0;
      end
      commit_d = commit_now;
   end

   always_ff @(posedge ram_clk or negedge sys_rst_l) begin
      if (!sys_rst_l) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         win_q    <= 2'd0;
         last_q   <= 2'd2;
         dirty_q  <= 1'b0;
         commit_q <= 1'b0;
         cnt_q    <= '0;
         pwm_q    <= '0;
         for (int r = 0; r < NREG; r++) begin
            shadow_q[r] <= '0;
            active_q[r] <= '0;
         end
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         win_q    <= win_d;
         last_q   <= last_d;
         dirty_q  <= dirty_d;
         commit_q <= commit_d;
         cnt_q    <= cnt_d;
         pwm_q    <= pwm_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign gnt_o    = gnt_q;
   assign commit_o = commit_q;
   assign cnt_o    = cnt_q;
   assign pwm_o    = pwm_q;

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Bench for pwm_cfg_arbiter: scenario tasks plus random traffic, compared each cycle
// against a register-map/cooldown model of the arbiter, shadow/active set and counter.
module tb_pwm_cfg_arbiter;

   localparam int CNT_W = 8;

   logic        ram_clk = 1'b0;
   logic        sys_rst_l;
   logic [2:0]  req_i;
   logic [5:0]  addr_i;
   logic [23:0] data_i;
   logic [2:0]  gnt_o;
   logic        commit_o;
   logic [7:0]  cnt_o;
   logic [2:0]  pwm_o;
   logic [14:0] obs;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // per-requester pending writes: {addr[1:0], data[7:0]}
   logic [9:0] wq [3][$];

   // reference model
   int         m_cnt;
   int         m_sh  [4];
   int         m_act [4];
   logic       m_dirty;
   logic       m_commit;
   logic [2:0] m_pwm;
   logic [2:0] m_gnt;
   int         m_last;
   int         m_cool;
   int         m_win;

   always #5 ram_clk = ~ram_clk;

   pwm_cfg_arbiter #(.CNT_W(CNT_W), .NCH(3)) dut (
      .ram_clk  (ram_clk),
      .sys_rst_l(sys_rst_l),
      .req_i    (req_i),
      .addr_i   (addr_i),
      .data_i   (data_i),
      .gnt_o    (gnt_o),
      .commit_o (commit_o),
      .cnt_o    (cnt_o),
      .pwm_o    (pwm_o)
   );

   assign obs = {gnt_o, commit_o, cnt_o, pwm_o};

   function automatic logic [14:0] exp_vec();
      return {m_gnt, m_commit, 8'(m_cnt), m_pwm};
   endfunction

   task automatic model_reset();
      m_cnt = 0;
      for (int r = 0; r < 4; r++) begin
         m_sh[r]  = 0;
         m_act[r] = 0;
      end
      m_dirty  = 1'b0;
      m_commit = 1'b0;
      m_pwm    = 3'b000;
      m_gnt    = 3'b000;
      m_last   = 2;
      m_cool   = 0;
      m_win    = 0;
   endtask

   // One clock edge of the register map: grant spacing is a 3-cycle cooldown,
   // the granted requester's write lands one edge after its grant.
   task automatic model_update();
      logic       wr;
      logic       wrap;
      logic       cm;
      logic [2:0] p;
      int         wa;
      int         wd;
      int         cand;
      wr   = (m_gnt != 3'b000);
      wa   = int'(addr_i[2*m_win +: 2]);
      wd   = int'(data_i[8*m_win +: 8]);
      wrap = (m_cnt == m_act[0]);
      cm   = wrap && m_dirty;
      for (int i = 0; i < 3; i++) p[i] = (m_cnt < m_act[i+1]);
      m_cnt = wrap ? 0 : (m_cnt + 1) % 256;
      if (cm) for (int r = 0; r < 4; r++) m_act[r] = m_sh[r];
      if (wr) m_sh[wa] = wd;
      if (wr) m_dirty = 1'b1;
      else if (cm) m_dirty = 1'b0;
      m_commit = cm;
      m_pwm    = p;
      if (m_cool == 0 && req_i != 3'b000) begin
         cand = 0;
         for (int k = 1; k <= 3; k++) begin
            cand = (m_last + k) % 3;
            if (req_i[cand]) break;
         end
         m_gnt  = 3'(1 << cand);
         m_win  = cand;
         m_last = cand;
         m_cool = 2;
      end else begin
         m_gnt = 3'b000;
         if (m_cool > 0) m_cool--;
      end
   endtask

   // Requesters react to gnt at the negedge: drop req on grant, load the next write afterwards.
   task automatic step();
      logic [9:0] w;
      for (int i = 0; i < 3; i++) begin
         if (gnt_o[i]) begin
            req_i[i] = 1'b0;
         end else if (!req_i[i] && wq[i].size() > 0) begin
            w = wq[i].pop_front();
            addr_i[2*i +: 2] = w[9:8];
            data_i[8*i +: 8] = w[7:0];
            req_i[i] = 1'b1;
         end
      end
      @(posedge ram_clk);
      if (!sys_rst_l) model_reset();
      else model_update();
      @(negedge ram_clk);
      cyc++;
   endtask

   task automatic do_reset();
      sys_rst_l = 1'b0;
      req_i     = 3'b000;
      addr_i    = '0;
      data_i    = '0;
      for (int i = 0; i < 3; i++) wq[i].delete();
      step();
      step();
      sys_rst_l = 1'b1;
   endtask

   task automatic test_reset();
      sys_rst_l = 1'b0;
      req_i     = 3'b111;
      addr_i    = 6'h3f;
      data_i    = 24'hffffff;
      for (int n = 0; n < 3; n++) begin
         step();
         checks++;
         if (obs !== 15'h0000) begin
            errors++;
            $display("FAIL reset_outputs cyc=%0d: got %h expected 0000", cyc, obs);
         end
      end
      req_i = 3'b000;
      sys_rst_l = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release cyc=%0d: got %h expected %h", cyc, obs, exp_vec());
         end
      end
      $display("test_reset done cyc=%0d", cyc);
   endtask

   task automatic test_basic();
      int  g[$];
      int  c[$];
      int  ones;
      bit  found;
      do_reset();
      wq[0].push_back({2'd0, 8'd9});
      wq[0].push_back({2'd1, 8'd3});
      for (int n = 0; n < 25; n++) begin
         step();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL basic_model cyc=%0d: got %h expected %h", cyc, obs, exp_vec());
         end
         if (gnt_o == 3'b001) g.push_back(cyc);
         if (commit_o) c.push_back(cyc);
      end
      checks++;
      if (g.size() != 2 || g[1] - g[0] != 3) begin
         errors++;
         $display("FAIL basic_grant_spacing: got %0d grants gap %0d expected 2 grants gap 3",
                  g.size(), (g.size() == 2) ? g[1] - g[0] : -1);
      end
      checks++;
      if (c.size() != 2) begin
         errors++;
         $display("FAIL basic_commit_count: got %0d expected 2", c.size());
      end
      found = 1'b0;
      for (int n = 0; n < 12 && !found; n++) begin
         if (cnt_o == 8'd0) found = 1'b1;
         else step();
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL basic_wait_wrap: got no cnt_o==0 within 12 cycles expected one");
      end
      ones = 0;
      for (int n = 0; n < 10; n++) begin
         step();
         ones += int'(pwm_o[0]);
      end
      checks++;
      if (cnt_o !== 8'd0) begin
         errors++;
         $display("FAIL basic_period: got cnt_o=%0d after 10 cycles expected 0", cnt_o);
      end
      checks++;
      if (ones != 3) begin
         errors++;
         $display("FAIL basic_duty: got %0d high cycles expected 3", ones);
      end
      $display("test_basic done cyc=%0d grants=%0d commits=%0d pwm0_high=%0d", cyc, g.size(), c.size(), ones);
   endtask

   task automatic test_round_robin();
      logic [2:0] gv[$];
      int         gc[$];
      logic [2:0] want [4];
      want[0] = 3'b001; want[1] = 3'b010; want[2] = 3'b100; want[3] = 3'b001;
      do_reset();
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < 4; k++)
            wq[i].push_back({2'($urandom_range(1, 3)), 8'($urandom_range(0, 255))});
      for (int n = 0; n < 20; n++) begin
         step();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL rr_model cyc=%0d: got %h expected %h", cyc, obs, exp_vec());
         end
         if (gnt_o != 3'b000) begin
            gv.push_back(gnt_o);
            gc.push_back(cyc);
         end
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (k >= gv.size() || gv[k] !== want[k]) begin
            errors++;
            $display("FAIL rr_order[%0d]: got %b expected %b", k, (k < gv.size()) ? gv[k] : 3'bxxx, want[k]);
         end else if (k > 0 && gc[k] - gc[k-1] != 3) begin
            errors++;
            $display("FAIL rr_spacing[%0d]: got gap %0d expected 3", k, gc[k] - gc[k-1]);
         end
      end
      $display("test_round_robin done cyc=%0d grants=%0d", cyc, gv.size());
   endtask

   task automatic test_commit_collision();
      int  cm[$];
      int  pw2[30];
      int  ones;
      bit  found;
      do_reset();
      wq[0].push_back({2'd0, 8'd9});
      for (int n = 0; n < 8; n++) begin
         step();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL coll_setup cyc=%0d: got %h expected %h", cyc, obs, exp_vec());
         end
      end
      found = 1'b0;
      for (int n = 0; n < 15 && !found; n++) begin
         if (cnt_o == 8'd2) found = 1'b1;
         else step();
      end
      wq[1].push_back({2'd1, 8'd2});
      for (int n = 0; n < 15 && found; n++) begin
         step();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL coll_dirty cyc=%0d: got %h expected %h", cyc, obs, exp_vec());
         end
         if (cnt_o == 8'd8) break;
      end
      checks++;
      if (!found || cnt_o !== 8'd8) begin
         errors++;
         $display("FAIL coll_wait_cnt8: got cnt_o=%0d expected 8", cnt_o);
      end
      wq[2].push_back({2'd3, 8'd5});
      for (int n = 0; n < 30; n++) begin
         step();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL coll_model cyc=%0d: got %h expected %h", cyc, obs, exp_vec());
         end
         pw2[n] = int'(pwm_o[2]);
         if (commit_o) cm.push_back(n);
         if (gnt_o[2]) begin
            checks++;
            if (cnt_o !== 8'd9) begin
               errors++;
               $display("FAIL coll_gnt_at_wrap: got cnt_o=%0d during grant expected 9", cnt_o);
            end
         end
      end
      checks++;
      if (cm.size() != 2 || cm[1] - cm[0] != 10) begin
         errors++;
         $display("FAIL coll_commits: got %0d commits gap %0d expected 2 commits gap 10",
                  cm.size(), (cm.size() == 2) ? cm[1] - cm[0] : -1);
      end
      ones = 0;
      if (cm.size() == 2) for (int n = cm[0]; n <= cm[1]; n++) ones += pw2[n];
      checks++;
      if (ones != 0) begin
         errors++;
         $display("FAIL coll_old_duty2: got %0d high cycles between commits expected 0", ones);
      end
      ones = 0;
      for (int n = 0; n < 10; n++) begin
         step();
         ones += int'(pwm_o[2]);
      end
      checks++;
      if (ones != 5) begin
         errors++;
         $display("FAIL coll_new_duty2: got %0d high cycles expected 5", ones);
      end
      $display("test_commit_collision done cyc=%0d commits=%0d pwm2_high=%0d", cyc, cm.size(), ones);
   endtask

   task automatic test_period_zero();
      int g[$];
      int c[$];
      int bad;
      do_reset();
      wq[0].push_back({2'd1, 8'd1});
      wq[1].push_back({2'd2, 8'd7});
      for (int n = 0; n < 20; n++) begin
         step();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL pz_model cyc=%0d: got %h expected %h", cyc, obs, exp_vec());
         end
         if (gnt_o != 3'b000) g.push_back(cyc);
         if (commit_o) c.push_back(cyc);
      end
      checks++;
      if (g.size() != 2 || c.size() != 2) begin
         errors++;
         $display("FAIL pz_counts: got %0d grants %0d commits expected 2 and 2", g.size(), c.size());
      end else begin
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (c[k] != g[k] + 2) begin
               errors++;
               $display("FAIL pz_commit_lat[%0d]: got %0d cycles expected 2", k, c[k] - g[k]);
            end
         end
      end
      bad = 0;
      for (int n = 0; n < 10; n++) begin
         step();
         if (cnt_o !== 8'd0 || pwm_o[0] !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL pz_steady: got %0d cycles with cnt_o!=0 or pwm0!=1 expected 0", bad);
      end
      $display("test_period_zero done cyc=%0d", cyc);
   endtask

   task automatic test_extreme_duty();
      int bad;
      do_reset();
      wq[0].push_back({2'd0, 8'd4});
      wq[0].push_back({2'd2, 8'd0});
      wq[1].push_back({2'd3, 8'd200});
      for (int n = 0; n < 25; n++) begin
         step();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL xd_model cyc=%0d: got %h expected %h", cyc, obs, exp_vec());
         end
      end
      bad = 0;
      for (int n = 0; n < 20; n++) begin
         step();
         if (pwm_o[1] !== 1'b0 || pwm_o[2] !== 1'b1 || cnt_o > 8'd4) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL xd_levels: got %0d bad cycles expected 0 (pwm1=0 pwm2=1 cnt<=4)", bad);
      end
      $display("test_extreme_duty done cyc=%0d", cyc);
   endtask

   task automatic test_reset_mid();
      bit         found;
      logic [2:0] first_gnt;
      int         ones;
      do_reset();
      wq[1].push_back({2'd1, 8'd77});
      found = 1'b0;
      for (int n = 0; n < 10 && !found; n++) begin
         step();
         if (gnt_o == 3'b010) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rm_wait_gnt: got no grant to requester 1 expected one");
      end
      sys_rst_l = 1'b0;
      #1;
      checks++;
      if (obs !== 15'h0000) begin
         errors++;
         $display("FAIL rm_async_clear: got %h expected 0000", obs);
      end
      req_i = 3'b000;
      for (int i = 0; i < 3; i++) wq[i].delete();
      step();
      checks++;
      if (obs !== 15'h0000) begin
         errors++;
         $display("FAIL rm_held: got %h expected 0000", obs);
      end
      wq[0].push_back({2'd0, 8'd9});
      wq[1].push_back({2'd2, 8'd50});
      sys_rst_l = 1'b1;
      first_gnt = 3'b000;
      for (int n = 0; n < 30; n++) begin
         step();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL rm_model cyc=%0d: got %h expected %h", cyc, obs, exp_vec());
         end
         if (first_gnt == 3'b000 && gnt_o != 3'b000) first_gnt = gnt_o;
      end
      checks++;
      if (first_gnt !== 3'b001) begin
         errors++;
         $display("FAIL rm_first_grant: got %b expected 001", first_gnt);
      end
      ones = 0;
      for (int n = 0; n < 10; n++) begin
         step();
         ones += int'(pwm_o[0]);
      end
      checks++;
      if (ones != 0) begin
         errors++;
         $display("FAIL rm_aborted_write: got %0d pwm0 high cycles expected 0", ones);
      end
      $display("test_reset_mid done cyc=%0d first_gnt=%b", cyc, first_gnt);
   endtask

   task automatic test_random();
      int i;
      int a;
      int d;
      do_reset();
      for (int n = 0; n < 700; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            i = $urandom_range(0, 2);
            a = $urandom_range(0, 3);
            d = (a == 0) ? $urandom_range(0, 20) : $urandom_range(0, 25);
            if (wq[i].size() < 2) wq[i].push_back({2'(a), 8'(d)});
         end
         step();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL random_model cyc=%0d: got %h expected %h", cyc, obs, exp_vec());
         end
      end
      $display("test_random done cyc=%0d", cyc);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got time limit expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      sys_rst_l = 1'b0;
      req_i     = 3'b000;
      addr_i    = '0;
      data_i    = '0;
      model_reset();
      test_reset();
      test_basic();
      test_round_robin();
      test_commit_collision();
      test_period_zero();
      test_extreme_duty();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pwm_cfg_arbiter.md
PWM_CFG_ARBITER -- requirements
Module: pwm_cfg_arbiter

Interface
REQ-001 Parameter: CNT_W, default 8, width of period/duty values and the period counter.
REQ-002 Parameter: NCH, fixed at 3, number of requesters and number of PWM channels.
REQ-003 ram_clk  input  1  clock; all logic on its rising edge.
REQ-004 sys_rst_l  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  3  per-requester register-write request; bit i = requester i.
REQ-006 addr_i  input  6  packed 2-bit register addresses; requester i uses bits [2i+1:2i].
REQ-007 data_i  input  3*CNT_W  packed write data; requester i uses bits [CNT_W*(i+1)-1:CNT_W*i].
REQ-008 gnt_o  output  3  one-hot grant pulse; write of that requester is accepted.
REQ-009 commit_o  output  1  one-cycle pulse; shadow registers copied to active registers.
REQ-010 cnt_o  output  CNT_W  current period counter value.
REQ-011 pwm_o  output  3  PWM outputs, channel 0..2.

Function
REQ-012 Register map: addr 0 = period, addr 1..3 = duty of channel 0..2; each has a shadow copy and an active copy.
REQ-013 Arbiter FSM states: IDLE, GNT, DONE; IDLE->GNT when any req_i bit is high; GNT->DONE always; DONE->IDLE always.
REQ-014 In IDLE, winner = round-robin: search starts at (last_grant+1) mod 3 and wraps; last_grant updates only on a grant.
REQ-015 gnt_o is registered: the winner's bit is high for exactly the GNT cycle; all other cycles gnt_o = 0.
REQ-016 Requester holds req/addr/data stable from assertion until it sees gnt high; it drops req no later than the DONE cycle.
REQ-017 req_i is ignored in GNT and DONE; a request still high in DONE is not granted twice.
REQ-018 Shadow write occurs at the end of the GNT cycle using the winner's addr/data sampled in that cycle; dirty flag is set.
REQ-019 Throughput: at most one write every 3 cycles; fairness: a continuously requesting requester waits at most 2 other grants.
REQ-020 Counter: cnt_o increments by 1 each cycle; when cnt_o == period_active it wraps to 0 on the next cycle.
REQ-021 period_active = 0: cnt_o stays 0 and a wrap occurs every cycle.
REQ-022 Commit: on a wrap cycle (cnt_o == period_active) with dirty = 1, all active registers load the shadow values held at the start of that cycle, and dirty clears.
REQ-023 commit_o pulses high in the cycle after the commit edge; it stays low if dirty = 0.
REQ-024 Simultaneous shadow write and commit: the active registers take the pre-write shadow values, the new write remains in shadow, and dirty stays 1 so the write commits at the next wrap.
REQ-025 pwm_o[i] is registered: pwm_o[i] <= (cnt_o < duty_active[i]), giving a 1-cycle latency from cnt_o.
REQ-026 duty 0 holds pwm_o[i] at 0; duty > period_active holds pwm_o[i] at 1; comparison is unsigned, CNT_W bits.
REQ-027 A new period takes effect only at commit; the counter never skips the wrap when the period shrinks, because the compare uses period_active.

Reset
REQ-028 While sys_rst_l = 0: FSM = IDLE, gnt_o = 0, commit_o = 0, cnt_o = 0, pwm_o = 0, dirty = 0.
REQ-029 Reset values: all shadow and active registers = 0; last_grant = 2, so requester 0 has first priority.
REQ-030 Reset asserted mid-transaction aborts it: no shadow write occurs and no grant is issued after release.
REQ-031 After release, normal operation starts on the first rising ram_clk edge; counting starts at 0.

Verification (CNT_W = 8)
REQ-032 After reset, requester 0 writes addr 0 with data 9, then addr 1 with data 3 -> gnt_o = 001 each time, 3 cycles apart; commit_o pulses after the next wrap; then period = 10 cycles and pwm_o[0] is high for 3 of them.
REQ-033 req_i = 111 held continuously -> grant order is 001, 010, 100, 001, with one grant every 3 cycles.
REQ-034 Write duty2 = 5 in the exact cycle cnt_o == period_active while dirty = 1 -> the first commit uses the old duty2; a second commit_o follows at the next wrap; then duty2 = 5.
REQ-035 period = 0, duty0 = 1 committed -> cnt_o is constantly 0, pwm_o[0] is constantly 1, and commit_o pulses one cycle after each write's commit.
REQ-036 period = 4, duty1 = 0 and duty2 = 200 -> pwm_o[1] is always 0 and pwm_o[2] is always 1.
REQ-037 sys_rst_l pulsed low during GNT -> after release all outputs are 0, no shadow change occurs, and the next grant goes to requester 0 if requesting.
